// File: rtl/laser_cover_counter.sv
// Coverage scorer for LASER: buffers the 40-point load stream, then on DONE counts
// the points lying within RADIUS_SQ of either latched centre, one point per cycle.
module laser_cover_counter #(
    parameter int N_PTS     = 40,
    parameter int RADIUS_SQ = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pt_valid_i,
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic       done_i,
    input  logic [3:0] c1x_i,
    input  logic [3:0] c1y_i,
    input  logic [3:0] c2x_i,
    input  logic [3:0] c2y_i,
    output logic [5:0] cover_o,
    output logic       cover_vld_o,
    output logic       busy_o,
    output logic       proto_err_o
);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COUNT  = 2'd2;
    localparam logic [1:0] S_REPORT = 2'd3;

    localparam logic [5:0] LAST_IDX = 6'(N_PTS - 1);
    localparam logic [8:0] RAD_SQ   = 9'(RADIUS_SQ);

    // Squared Euclidean distance on the unsigned 4-bit grid (max 450).
    function automatic logic [8:0] dist_sq(input logic [3:0] px, input logic [3:0] py,
                                           input logic [3:0] cx, input logic [3:0] cy);
        logic signed [4:0] dx;
        logic signed [4:0] dy;
        logic signed [9:0] ex;
        logic signed [9:0] ey;
        logic signed [9:0] sum;
        dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
        dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
        ex  = 10'(dx);
        ey  = 10'(dy);
        sum = ex * ex + ey * ey;
        return sum[8:0];
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  wr_ptr_q, wr_ptr_d;
    logic [5:0]  idx_q, idx_d;
    logic [5:0]  acc_q, acc_d;
    logic [5:0]  cover_q, cover_d;
    logic        vld_q, vld_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [15:0] cen_q, cen_d;
    logic [7:0]  pt_mem_q [N_PTS];
    logic        wr_en_s;
    logic [7:0]  cur_pt_s;
    logic        covered_s;

    assign cur_pt_s  = pt_mem_q[idx_q];
    // A point near both centres is still one point: OR the two tests, never add them.
    assign covered_s = (dist_sq(cur_pt_s[7:4], cur_pt_s[3:0], cen_q[15:12], cen_q[11:8]) <= RAD_SQ) ||
                       (dist_sq(cur_pt_s[7:4], cur_pt_s[3:0], cen_q[7:4],   cen_q[3:0])  <= RAD_SQ);

    // Next-state logic for the load / wait / count / report sequence.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        cover_d  = cover_q;
        vld_d    = 1'b0;
        err_d    = err_q;
        cen_d    = cen_q;
        wr_en_s  = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (pt_valid_i) begin
                    wr_en_s  = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    wr_ptr_d = wr_ptr_q;
                end
                // DONE before any point is a leftover from the previous pattern.
                if (done_i && (wr_ptr_q != 6'd0)) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            S_WAIT: begin
                if (pt_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (done_i) begin
                    cen_d   = {c1x_i, c1y_i, c2x_i, c2y_i};
                    acc_d   = 6'd0;
                    idx_d   = 6'd0;
                    state_d = S_COUNT;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_COUNT: begin
                if (pt_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
                if (covered_s) begin
                    acc_d = acc_q + 6'd1;
                end else begin
                    acc_d = acc_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_REPORT;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_REPORT: begin
                cover_d  = acc_q;
                vld_d    = 1'b1;
                wr_ptr_d = 6'd0;
                state_d  = S_LOAD;
            end
            default: begin
                state_d  = S_LOAD;
                wr_ptr_d = 6'd0;
            end
        endcase
        busy_d = (state_d == S_WAIT) || (state_d == S_COUNT);
    end

    // Control and output registers; reset aborts any pattern in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_LOAD;
            wr_ptr_q <= 6'd0;
            idx_q    <= 6'd0;
            acc_q    <= 6'd0;
            cover_q  <= 6'd0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            cen_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            cover_q  <= cover_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            cen_q    <= cen_d;
        end
    end

    // Point buffer; contents are don't-care after reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            pt_mem_q[wr_ptr_q] <= {x_i, y_i};
        end
    end

    assign cover_o     = cover_q;
    assign cover_vld_o = vld_q;
    assign busy_o      = busy_q;
    assign proto_err_o = err_q;

endmodule

// File: tb/tb_laser_cover_counter.sv
// Self-checking bench for laser_cover_counter: table of patterns with hand-derived
// cover counts, a scoreboard queue of expected COVER values, plus protocol/reset corners.
module tb_laser_cover_counter;

    localparam int N = 40;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       pt_valid_i;
    logic [3:0] x_i, y_i;
    logic       done_i;
    logic [3:0] c1x_i, c1y_i, c2x_i, c2y_i;
    logic [5:0] cover_o;
    logic       cover_vld_o, busy_o, proto_err_o;

    laser_cover_counter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pt_valid_i  (pt_valid_i),
        .x_i         (x_i),
        .y_i         (y_i),
        .done_i      (done_i),
        .c1x_i       (c1x_i),
        .c1y_i       (c1y_i),
        .c2x_i       (c2x_i),
        .c2y_i       (c2y_i),
        .cover_o     (cover_o),
        .cover_vld_o (cover_vld_o),
        .busy_o      (busy_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] ax, ay, bx, by;
        int         split;
        logic [3:0] c1x, c1y, c2x, c2y;
        logic [5:0] exp_cover;
    } pat_t;

    pat_t       tbl [6];
    logic [5:0] sb_q [$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_points(input pat_t p, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            pt_valid_i = 1'b1;
            x_i = (i < p.split) ? p.ax : p.bx;
            y_i = (i < p.split) ? p.ay : p.by;
            step();
        end
        pt_valid_i = 1'b0;
    endtask

    // Issue DONE, scramble the centre inputs afterwards, wait for and score the report.
    task automatic finish_pattern(input pat_t p, input bit keep_done, input bit exp_err);
        int  n;
        bit  seen;
        logic [5:0] exp_c;
        c1x_i = p.c1x; c1y_i = p.c1y; c2x_i = p.c2x; c2y_i = p.c2y;
        done_i = 1'b1;
        step();
        sb_q.push_back(p.exp_cover);
        c1x_i = ~p.c1x; c1y_i = ~p.c1y; c2x_i = ~p.c2x; c2y_i = ~p.c2y;
        if (!keep_done) done_i = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            step();
            n++;
            if (n == 1) check("busy_in_count", busy_o, 1);
            if (cover_vld_o) begin
                seen = 1'b1;
                check("vld_latency", n, 41);
                check("busy_at_report", busy_o, 0);
                if (sb_q.size() > 0) begin
                    exp_c = sb_q.pop_front();
                    check("cover", cover_o, exp_c);
                end else begin
                    check("scoreboard_empty", 1, 0);
                end
            end
        end
        if (!seen) check("vld_timeout", n, 41);
        step();
        check("vld_one_cycle", cover_vld_o, 0);
        check("cover_hold", cover_o, p.exp_cover);
        if (keep_done) begin
            step();
            done_i = 1'b0;
        end
        check("proto_err", proto_err_o, exp_err);
    endtask

    initial begin
        tbl[0] = '{4'd8, 4'd8, 4'd8, 4'd8, 40,  4'd8,  4'd8,  4'd0, 4'd0, 6'd40};
        tbl[1] = '{4'd0, 4'd0, 4'd0, 4'd0, 40,  4'd15, 4'd15, 4'd4, 4'd0, 6'd40};
        tbl[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 40,  4'd15, 4'd15, 4'd4, 4'd1, 6'd0};
        tbl[3] = '{4'd0, 4'd0, 4'd15, 4'd15, 20, 4'd0, 4'd0, 4'd15, 4'd15, 6'd40};
        tbl[4] = '{4'd0, 4'd0, 4'd15, 4'd15, 20, 4'd0, 4'd0, 4'd0,  4'd0,  6'd20};
        tbl[5] = '{4'd3, 4'd3, 4'd10, 4'd12, 10, 4'd7, 4'd3, 4'd10, 4'd7,  6'd10};

        rst_i = 1'b1; pt_valid_i = 1'b0; x_i = 4'd0; y_i = 4'd0; done_i = 1'b0;
        c1x_i = 4'd0; c1y_i = 4'd0; c2x_i = 4'd0; c2y_i = 4'd0;
        step(); step();
        check("rst_cover", cover_o, 0);
        check("rst_vld", cover_vld_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", proto_err_o, 0);
        rst_i = 1'b0;
        step();

        // Back-to-back patterns; odd entries leave DONE high into the next load start.
        for (int i = 0; i < 6; i++) begin
            load_points(tbl[i], 0, N);
            check("busy_in_wait", busy_o, 1);
            finish_pattern(tbl[i], (i % 2) == 1, 1'b0);
        end

        // Early DONE, then a stray point while waiting for DONE.
        load_points(tbl[0], 0, 5);
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        check("early_done_err", proto_err_o, 1);
        load_points(tbl[0], 5, N);
        pt_valid_i = 1'b1; x_i = 4'd0; y_i = 4'd0;
        step();
        pt_valid_i = 1'b0;
        check("wait_pt_err", proto_err_o, 1);
        finish_pattern('{4'd8, 4'd8, 4'd8, 4'd8, 40, 4'd8, 4'd8, 4'd15, 4'd15, 6'd40}, 1'b0, 1'b1);

        // Asynchronous reset in the middle of counting, then a clean rerun.
        load_points(tbl[0], 0, N);
        c1x_i = 4'd8; c1y_i = 4'd8; c2x_i = 4'd0; c2y_i = 4'd0;
        done_i = 1'b1;
        step();
        done_i = 1'b0;
        for (int i = 0; i < 17; i++) step();
        check("busy_before_rst", busy_o, 1);
        rst_i = 1'b1;
        #1;
        check("arst_cover", cover_o, 0);
        check("arst_vld", cover_vld_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_err", proto_err_o, 0);
        step();
        rst_i = 1'b0;
        step();
        load_points(tbl[0], 0, N);
        finish_pattern(tbl[0], 1'b0, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
